// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing datapath.
// Keeps encoder and decoder window widths in agreement.
package sc_pkg;

  localparam int SC_WIN_LOG2 = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_state_e;

endpackage

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a 2^WIN_LOG2 sample
// window and returns a unipolar or bipolar binary estimate.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIN_LOG2 = SC_WIN_LOG2,
  parameter bit BIPOLAR  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                busy,
  output logic [WIN_LOG2+1:0] result,
  output logic                result_valid,
  input  logic                result_ready
);

  localparam int CW = WIN_LOG2 + 1;
  localparam int RW = WIN_LOG2 + 2;
  localparam logic [CW-1:0] N_CNT = CW'(1) << WIN_LOG2;

  sc_state_e     state;
  logic [CW-1:0] ones_q;
  logic [CW-1:0] samp_q;
  logic [CW-1:0] ones_nx;
  logic          last;
  logic [RW-1:0] res_nx;

  assign ones_nx = ones_q + CW'(bit_in);
  assign last    = bit_valid && (samp_q == N_CNT - CW'(1));

  // Final value from the count including the sample taken this cycle
  always_comb begin
    res_nx = {1'b0, ones_nx};
    if (BIPOLAR) begin
      res_nx = {ones_nx, 1'b0} - {1'b0, N_CNT};
    end
  end

  // Window FSM with counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ones_q       <= '0;
      samp_q       <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            ones_q <= '0;
            samp_q <= '0;
          end
        end
        RUN: begin
          if (bit_valid) begin
            samp_q <= samp_q + CW'(1);
            ones_q <= ones_nx;
            if (last) begin
              state        <= DONE;
              busy         <= 1'b0;
              result       <= res_nx;
              result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (start) begin
              state  <= RUN;
              busy   <= 1'b1;
              ones_q <= '0;
              samp_q <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
